// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus between program memory, instruction decoder and pc_fetch_unit.
interface pc_fetch_unit_if #(
  parameter int unsigned PC_WIDTH = 13,
  parameter int unsigned IW       = 14,
  parameter int unsigned DEPTH_W  = 4
);
  logic [PC_WIDTH-1:0] imem_addr;
  logic [IW-1:0]       imem_rdata;
  logic [IW-1:0]       instr_current;
  logic [PC_WIDTH-1:0] pc;
  logic                instr_rd_en;
  logic                instr_flush;
  logic                pc_incr_en;
  logic                pc_j_en;
  logic                stack_push;
  logic                stack_pop;
  logic                pcl_wr_en;
  logic [7:0]          pcl_wr_data;
  logic [4:0]          pclath;
  logic [DEPTH_W-1:0]  stack_depth;

  modport master (
    input  imem_addr, instr_current, pc, stack_depth,
    output imem_rdata, instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
           stack_push, stack_pop, pcl_wr_en, pcl_wr_data, pclath
  );

  modport slave (
    output imem_addr, instr_current, pc, stack_depth,
    input  imem_rdata, instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
           stack_push, stack_pop, pcl_wr_en, pcl_wr_data, pclath
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC, instruction register with single-word prefetch, and circular hardware return stack.
// Executes the fetch strobes issued by the instruction decoder.
module pc_fetch_unit #(
  parameter int unsigned PC_WIDTH    = 13,
  parameter int unsigned STACK_DEPTH = 8,
  parameter logic [13:0] NOP_WORD    = 14'h0000
) (
  input logic            clk,
  input logic            rst_n,
  pc_fetch_unit_if.slave bus
);
  localparam int unsigned IW      = 14;
  localparam int unsigned SP_W    = $clog2(STACK_DEPTH);
  localparam int unsigned DEPTH_W = SP_W + 1;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_top;
  logic                pop_eff;

  assign stack_top = stack_q[sp_q - SP_W'(1)];
  // Simultaneous push and pop is illegal from the decoder; push takes the stack.
  assign pop_eff   = bus.stack_pop & ~bus.stack_push;

  // Next-state: PC priority j > pop > pcl write > incr; IR flush > read.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    sp_d    = sp_q;
    depth_d = depth_q;

    if (bus.pc_j_en)
      pc_d = PC_WIDTH'({bus.pclath[4:3], ir_q[10:0]});
    else if (bus.stack_pop)
      pc_d = stack_top;
    else if (bus.pcl_wr_en)
      pc_d = PC_WIDTH'({bus.pclath, bus.pcl_wr_data});
    else if (bus.pc_incr_en)
      pc_d = pc_q + PC_WIDTH'(1);

    if (bus.instr_flush)
      ir_d = NOP_WORD;
    else if (bus.instr_rd_en)
      ir_d = bus.imem_rdata;

    if (bus.stack_push) begin
      sp_d = sp_q + SP_W'(1);
      if (depth_q != DEPTH_W'(STACK_DEPTH))
        depth_d = depth_q + DEPTH_W'(1);
    end else if (pop_eff) begin
      sp_d = sp_q - SP_W'(1);
      if (depth_q != DEPTH_W'(0))
        depth_d = depth_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= '0;
      ir_q    <= NOP_WORD;
      sp_q    <= '0;
      depth_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

  // Stack storage keeps its contents through reset; a push is blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && bus.stack_push)
      stack_q[sp_q] <= pc_q;
  end

  assign bus.pc            = pc_q;
  assign bus.imem_addr     = pc_q;
  assign bus.instr_current = ir_q;
  assign bus.stack_depth   = depth_q;
endmodule
